fir_xifu_mac_sched: RTL and testbench

Sequential multiply-accumulate scheduler for the FIR XIFU. It owns the tap coefficient buffer and the sample delay line. It accepts one new sample per request and computes the FIR output over NB_TAPS cycles using a single shared multiplier. The result is returned on a valid/ready response channel. It sits between the XIFU decode/issue logic, which issues tap writes and compute requests, and the writeback stage, which consumes results tagged with the originating instruction id.

---
 rtl/fir_xifu_mac_sched_if.sv | 35 +++
 rtl/fir_xifu_mac_sched.sv | 104 ++++++++++
 tb/tb_fir_xifu_mac_sched.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_xifu_mac_sched_if.sv
// Issue/writeback bundle for the FIR MAC scheduler: tap writes, compute requests, results.
interface fir_xifu_mac_sched_if #(
    parameter int NB_TAPS    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 4
);
    localparam int IDX_W = $clog2(NB_TAPS);

    logic                  clear_i;
    logic                  tap_we_i;
    logic [IDX_W-1:0]      tap_idx_i;
    logic [DATA_WIDTH-1:0] tap_data_i;
    logic                  tap_ready_o;
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [DATA_WIDTH-1:0] req_sample_i;
    logic [ID_WIDTH-1:0]   req_id_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [31:0]           rsp_data_o;
    logic [ID_WIDTH-1:0]   rsp_id_o;
    logic                  busy_o;

    modport master (
        output clear_i, tap_we_i, tap_idx_i, tap_data_i,
        output req_valid_i, req_sample_i, req_id_i, rsp_ready_i,
        input  tap_ready_o, req_ready_o, rsp_valid_o, rsp_data_o, rsp_id_o, busy_o
    );

    modport slave (
        input  clear_i, tap_we_i, tap_idx_i, tap_data_i,
        input  req_valid_i, req_sample_i, req_id_i, rsp_ready_i,
        output tap_ready_o, req_ready_o, rsp_valid_o, rsp_data_o, rsp_id_o, busy_o
    );
endinterface

// File: rtl/fir_xifu_mac_sched.sv
// Sequential FIR MAC: one shared multiplier, result NB_TAPS+1 cycles after request accept.
// Held result stalls new requests; DONE accepts the next request when the result drains.
module fir_xifu_mac_sched #(
    parameter int NB_TAPS    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 4
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    fir_xifu_mac_sched_if.slave bus
);
    localparam int IDX_W = $clog2(NB_TAPS);
    localparam int ACC_W = 2 * DATA_WIDTH + IDX_W;
    localparam int EXT_W = ACC_W + 33;
    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-31){1'b0}}, {31{1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-31){1'b1}}, {31{1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

    state_e                         state_q, state_d;
    logic signed [DATA_WIDTH-1:0]   taps_q    [NB_TAPS];
    logic signed [DATA_WIDTH-1:0]   samples_q [NB_TAPS];
    logic signed [ACC_W-1:0]        acc_q;
    logic        [IDX_W-1:0]        cnt_q;
    logic        [ID_WIDTH-1:0]     id_q;
    logic                           req_fire, tap_fire, last_tap;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [EXT_W-1:0]        acc_ext;

    assign prod     = taps_q[cnt_q] * samples_q[cnt_q];
    assign last_tap = (cnt_q == IDX_W'(NB_TAPS - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        bus.req_ready_o = 1'b0;
        bus.tap_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready_o = !bus.clear_i;
                bus.tap_ready_o = !bus.clear_i;
            end
            DONE:    bus.req_ready_o = bus.rsp_ready_i && !bus.clear_i;
            default: ;
        endcase
        req_fire = bus.req_valid_i && bus.req_ready_o;
        tap_fire = bus.tap_we_i && bus.tap_ready_o && (32'(bus.tap_idx_i) < NB_TAPS);
        case (state_q)
            IDLE: if (req_fire) state_d = MAC;
            MAC:  if (last_tap) state_d = DONE;
            DONE: begin
                if (req_fire)             state_d = MAC;
                else if (bus.rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Flush wins over every transition, including a handshake in the same cycle.
        if (bus.clear_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NB_TAPS; i++) begin
                taps_q[i]    <= '0;
                samples_q[i] <= '0;
            end
            acc_q <= '0;
            cnt_q <= '0;
            id_q  <= '0;
        end else begin
            if (tap_fire) taps_q[bus.tap_idx_i] <= bus.tap_data_i;
            if (bus.clear_i) begin
                for (int i = 0; i < NB_TAPS; i++) samples_q[i] <= '0;
                acc_q <= '0;
                cnt_q <= '0;
            end else if (req_fire) begin
                samples_q[0] <= bus.req_sample_i;
                for (int i = 1; i < NB_TAPS; i++) samples_q[i] <= samples_q[i-1];
                acc_q <= '0;
                cnt_q <= '0;
                id_q  <= bus.req_id_i;
            end else if (state_q == MAC) begin
                acc_q <= acc_q + ACC_W'(prod);
                cnt_q <= cnt_q + IDX_W'(1);
            end
        end
    end

    // Result is a pure function of the held accumulator, so it cannot move under backpressure.
    always_comb begin
        acc_ext = {{33{acc_q[ACC_W-1]}}, acc_q};
        if (acc_ext > SAT_MAX)      bus.rsp_data_o = 32'h7FFF_FFFF;
        else if (acc_ext < SAT_MIN) bus.rsp_data_o = 32'h8000_0000;
        else                        bus.rsp_data_o = acc_ext[31:0];
    end

    assign bus.rsp_valid_o = (state_q == DONE);
    assign bus.rsp_id_o    = id_q;
    assign bus.busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_fir_xifu_mac_sched.sv
// Bench for fir_xifu_mac_sched: directed vector table, hand corner sequences, random traffic vs dot-product model.
module tb_fir_xifu_mac_sched;
    localparam int NB = 4;
    localparam int DW = 16;
    localparam int IW = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear, tap_we, req_valid, rsp_ready;
    logic [1:0]  tap_idx;
    logic [15:0] tap_data, req_sample;
    logic [3:0]  req_id;
    logic        tap_ready, req_ready, rsp_valid, busy;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_id;

    fir_xifu_mac_sched_if #(.NB_TAPS(NB), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    assign bus.clear_i      = clear;
    assign bus.tap_we_i     = tap_we;
    assign bus.tap_idx_i    = tap_idx;
    assign bus.tap_data_i   = tap_data;
    assign bus.req_valid_i  = req_valid;
    assign bus.req_sample_i = req_sample;
    assign bus.req_id_i     = req_id;
    assign bus.rsp_ready_i  = rsp_ready;
    assign tap_ready = bus.tap_ready_o;
    assign req_ready = bus.req_ready_o;
    assign rsp_valid = bus.rsp_valid_o;
    assign rsp_data  = bus.rsp_data_o;
    assign rsp_id    = bus.rsp_id_o;
    assign busy      = bus.busy_o;

    fir_xifu_mac_sched #(.NB_TAPS(NB), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: result = saturated dot product of taps and sample history, due NB+1 cycles after accept.
    shortint     m_taps [NB];
    shortint     m_samp [NB];
    bit          m_pend;
    int          m_acc_cyc;
    logic [31:0] m_data;
    logic [3:0]  m_id;

    function automatic logic [31:0] sat32(input longint v);
        if (v > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'h8000_0000;
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_fir();
        longint s;
        s = 0;
        for (int i = 0; i < NB; i++) s += longint'(m_taps[i]) * longint'(m_samp[i]);
        return sat32(s);
    endfunction

    task automatic monitor();
        bit done, e_tap, e_req;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                for (int i = 0; i < NB; i++) begin
                    m_taps[i] = 0;
                    m_samp[i] = 0;
                end
                m_pend = 0;
                continue;
            end
            done  = m_pend && (cyc - m_acc_cyc >= NB + 1);
            e_tap = !clear && !m_pend;
            e_req = !clear && (!m_pend || (done && rsp_ready));
            chk("mon_tap_ready", tap_ready, e_tap);
            chk("mon_req_ready", req_ready, e_req);
            chk("mon_rsp_valid", rsp_valid, done);
            chk("mon_busy", busy, m_pend);
            if (done) begin
                chk("mon_rsp_data", rsp_data, m_data);
                chk("mon_rsp_id", rsp_id, m_id);
            end
            if (clear) begin
                for (int i = 0; i < NB; i++) m_samp[i] = 0;
                m_pend = 0;
            end else begin
                if (tap_we && e_tap && int'(tap_idx) < NB) m_taps[tap_idx] = shortint'(tap_data);
                if (done && rsp_ready) m_pend = 0;
                if (req_valid && e_req) begin
                    for (int i = NB - 1; i > 0; i--) m_samp[i] = m_samp[i-1];
                    m_samp[0] = shortint'(req_sample);
                    m_data    = model_fir();
                    m_id      = req_id;
                    m_pend    = 1;
                    m_acc_cyc = cyc;
                end
            end
        end
    endtask

    typedef struct packed {
        logic            wr;
        logic [3:0][15:0] t;
        logic            clr;
        logic [15:0]     s;
        logic [3:0]      id;
        logic [31:0]     exp;
    } vec_t;

    vec_t vt [13];
    int   n;
    int   acc_at [3];

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr_tap(input logic [1:0] idx, input logic [15:0] val);
        tap_we = 1; tap_idx = idx; tap_data = val;
        @(negedge clk_i);
        chk("wr_tap_ready", tap_ready, 1'b1);
        step();
        tap_we = 0;
    endtask

    task automatic pulse_clear();
        clear = 1;
        step();
        clear = 0;
    endtask

    task automatic wait_rsp(input string tag, input logic [31:0] exp_d, input logic [3:0] exp_id);
        n = 0;
        do begin @(negedge clk_i); n++; end while (!rsp_valid && n < 50);
        chk({tag, "_valid"}, rsp_valid, 1'b1);
        chk({tag, "_latency"}, n, NB + 1);
        chk({tag, "_data"}, rsp_data, exp_d);
        chk({tag, "_id"}, rsp_id, exp_id);
    endtask

    task automatic issue(input string tag, input logic [15:0] s, input logic [3:0] id, input logic [31:0] exp_d);
        req_valid = 1; req_sample = s; req_id = id;
        n = 0;
        do begin @(negedge clk_i); n++; end while (!req_ready && n < 50);
        chk({tag, "_accept"}, req_ready, 1'b1);
        step();
        req_valid = 0;
        wait_rsp(tag, exp_d, id);
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear = 0; tap_we = 0; tap_idx = 0; tap_data = 0;
        req_valid = 0; req_sample = 0; req_id = 0; rsp_ready = 1;
        vt[0]  = '{wr:1, t:{16'd4, 16'd3, 16'd2, 16'd1}, clr:1, s:16'd10, id:4'd1, exp:32'd10};
        vt[1]  = '{wr:0, t:'0, clr:0, s:16'd20, id:4'd2, exp:32'd40};
        vt[2]  = '{wr:0, t:'0, clr:0, s:16'd30, id:4'd3, exp:32'd100};
        vt[3]  = '{wr:1, t:{4{16'h8000}}, clr:1, s:16'h8000, id:4'd4, exp:32'h4000_0000};
        vt[4]  = '{wr:0, t:'0, clr:0, s:16'h8000, id:4'd5, exp:32'h7FFF_FFFF};
        vt[5]  = '{wr:0, t:'0, clr:0, s:16'h8000, id:4'd6, exp:32'h7FFF_FFFF};
        vt[6]  = '{wr:0, t:'0, clr:0, s:16'h8000, id:4'd7, exp:32'h7FFF_FFFF};
        vt[7]  = '{wr:1, t:{16'd0, 16'd0, 16'd2, 16'hFFFF}, clr:1, s:16'd7, id:4'd8, exp:32'hFFFF_FFF9};
        vt[8]  = '{wr:0, t:'0, clr:0, s:16'hFFFD, id:4'd9, exp:32'h0000_0011};
        vt[9]  = '{wr:1, t:{4{16'h8000}}, clr:1, s:16'h7FFF, id:4'hA, exp:32'hC000_8000};
        vt[10] = '{wr:0, t:'0, clr:0, s:16'h7FFF, id:4'hB, exp:32'h8001_0000};
        vt[11] = '{wr:0, t:'0, clr:0, s:16'h7FFF, id:4'hC, exp:32'h8000_0000};
        vt[12] = '{wr:0, t:'0, clr:1, s:16'h7FFF, id:4'hF, exp:32'hC000_8000};

        fork monitor(); join_none

        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1;
        @(negedge clk_i);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_id", rsp_id, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_tap_ready", tap_ready, 1'b1);
        step();

        // Back-to-back stream with req_valid held: accepts land every NB+1 cycles.
        for (int k = 0; k < NB; k++) wr_tap(2'(k), 16'(k + 1));
        pulse_clear();
        req_valid = 1;
        for (int k = 0; k < 3; k++) begin
            req_sample = 16'(10 * (k + 1));
            req_id     = 4'(k + 1);
            n = 0;
            do begin @(negedge clk_i); n++; end while (!req_ready && n < 50);
            chk("stream_accept", req_ready, 1'b1);
            acc_at[k] = cyc;
            step();
        end
        req_valid = 0;
        chk("stream_spacing_1", acc_at[1] - acc_at[0], NB + 1);
        chk("stream_spacing_2", acc_at[2] - acc_at[1], NB + 1);
        n = 0;
        do begin @(negedge clk_i); n++; end while (busy && n < 50);
        chk("stream_drain", busy, 1'b0);
        step();

        for (int v = 0; v < 13; v++) begin
            if (vt[v].wr) for (int k = 0; k < NB; k++) wr_tap(2'(k), vt[v].t[k]);
            if (vt[v].clr) pulse_clear();
            issue($sformatf("vec%0d", v), vt[v].s, vt[v].id, vt[v].exp);
        end

        // Backpressure: result held for 7 cycles while the next request waits.
        for (int k = 0; k < NB; k++) wr_tap(2'(k), 16'(k + 1));
        pulse_clear();
        rsp_ready = 0; req_valid = 1; req_sample = 16'd10; req_id = 4'd5;
        @(negedge clk_i);
        chk("bp_first_accept", req_ready, 1'b1);
        step();
        req_sample = 16'd20; req_id = 4'd6;
        n = 0;
        do begin @(negedge clk_i); n++; end while (!rsp_valid && n < 50);
        chk("bp_valid", rsp_valid, 1'b1);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk_i);
            chk("bp_hold_data", rsp_data, 32'd10);
            chk("bp_hold_id", rsp_id, 4'd5);
            chk("bp_req_ready_low", req_ready, 1'b0);
        end
        step();
        rsp_ready = 1;
        @(negedge clk_i);
        chk("bp_accept_on_ready", req_ready, 1'b1);
        step();
        req_valid = 0;
        wait_rsp("bp_next", 32'd40, 4'd6);
        step();

        // Clear in the second MAC cycle aborts the request and zeroes the sample line.
        req_valid = 1; req_sample = 16'd99; req_id = 4'd7;
        @(negedge clk_i);
        chk("clr_accept", req_ready, 1'b1);
        step();
        req_valid = 0;
        step();
        pulse_clear();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            chk("clr_no_rsp", rsp_valid, 1'b0);
            chk("clr_not_busy", busy, 1'b0);
        end
        step();
        issue("clr_next", 16'd5, 4'd8, 32'd5);

        // Tap write during MAC is dropped: samples {3,5} give 13, then {1,3,5} give 22.
        req_valid = 1; req_sample = 16'd3; req_id = 4'd9;
        @(negedge clk_i);
        chk("busywr_accept", req_ready, 1'b1);
        step();
        req_valid = 0; tap_we = 1; tap_idx = 2'd0; tap_data = 16'd100;
        @(negedge clk_i);
        chk("busywr_tap_ready", tap_ready, 1'b0);
        step();
        tap_we = 0;
        n = 0;
        do begin @(negedge clk_i); n++; end while (!rsp_valid && n < 50);
        chk("busywr_data", rsp_data, 32'd13);
        step();
        issue("busywr_next", 16'd1, 4'd10, 32'd22);

        // Tap write and request in the same IDLE cycle: new tap is used.
        for (int k = 0; k < NB; k++) wr_tap(2'(k), 16'd0);
        pulse_clear();
        tap_we = 1; tap_idx = 2'd0; tap_data = 16'd7;
        req_valid = 1; req_sample = 16'd2; req_id = 4'd11;
        @(negedge clk_i);
        chk("simul_tap_ready", tap_ready, 1'b1);
        chk("simul_req_ready", req_ready, 1'b1);
        step();
        tap_we = 0; req_valid = 0;
        wait_rsp("simul", 32'd14, 4'd11);
        step();

        // Asynchronous reset mid-MAC: everything back to reset values, no response.
        req_valid = 1; req_sample = 16'd50; req_id = 4'd12;
        @(negedge clk_i);
        chk("arst_accept", req_ready, 1'b1);
        step();
        req_valid = 0;
        @(posedge clk_i);
        #3 rst_ni = 0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_rsp_valid", rsp_valid, 1'b0);
        chk("arst_rsp_data", rsp_data, 32'h0);
        chk("arst_rsp_id", rsp_id, 4'h0);
        chk("arst_req_ready", req_ready, 1'b1);
        chk("arst_tap_ready", tap_ready, 1'b1);
        @(posedge clk_i);
        #2 rst_ni = 1;
        step();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            chk("arst_no_rsp", rsp_valid, 1'b0);
        end
        step();
        wr_tap(2'd0, 16'd3);
        issue("arst_next", 16'd9, 4'd13, 32'd27);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            req_valid  = 1'($urandom_range(0, 1));
            req_sample = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
            req_id     = 4'($urandom);
            rsp_ready  = ($urandom_range(0, 9) < 7);
            tap_we     = ($urandom_range(0, 4) == 0);
            tap_idx    = 2'($urandom);
            tap_data   = ($urandom_range(0, 2) == 0) ? 16'h8000 : 16'($urandom);
            clear      = ($urandom_range(0, 49) == 0);
            step();
        end
        req_valid = 0; tap_we = 0; clear = 0; rsp_ready = 1;
        repeat (12) step();
        @(negedge clk_i);
        chk("final_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
